spine_egress_scheduler: RTL and testbench

Packet-level scheduler that shares the single router-to-NI delivery path among the four spine ingress ports (spine1..spine4) of a leaf router. Each spine presents fixed-length packets of 16-bit flits. The block grants one spine at a time for a whole packet using round-robin, and throttles delivery with a credit counter mirroring the NI receive buffer. It sits between the spine input FIFOs and the router's GPU-side output.

---
 rtl/spine_egress_scheduler_pkg.sv | 20 ++
 rtl/spine_egress_scheduler_if.sv | 31 +++
 rtl/spine_egress_scheduler_arb.sv | 29 ++
 rtl/spine_egress_scheduler.sv | 109 ++++++++++
 tb/tb_spine_egress_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spine_egress_scheduler_pkg.sv
// Shared NoC definitions for the leaf-router spine egress path.
// Contents: flit width and dest-address field position, number of spine
// requesters, the scheduler state encoding, and a dest-field helper.
package noc_pkg;

    localparam int unsigned FLIT_W     = 16;
    localparam int unsigned DEST_MSB   = 15;
    localparam int unsigned DEST_LSB   = 10;
    localparam int unsigned NUM_SPINES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    function automatic logic [DEST_MSB-DEST_LSB:0] flit_dest(input logic [FLIT_W-1:0] flit);
        return flit[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/spine_egress_scheduler_if.sv
// Handshake bundle between the spine input FIFOs / NI and the egress scheduler.
//   req_data      : NREQ flits, spine i at [i*DWIDTH +: DWIDTH]
//   req_valid     : per-spine flit available
//   req_ready     : per-spine flit accepted (valid & ready)
//   out_data      : registered flit towards the NI
//   out_valid     : one-cycle pulse per delivered flit
//   credit_return : NI freed one receive-buffer slot
// master = spine FIFO / NI side, slave = scheduler.
interface spine_egress_scheduler_if
    import noc_pkg::*;
#(
    parameter int unsigned DWIDTH = FLIT_W,
    parameter int unsigned NREQ   = NUM_SPINES
);
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DWIDTH-1:0]      out_data;
    logic                   out_valid;
    logic                   credit_return;

    modport master (
        output req_data, req_valid, credit_return,
        input  req_ready, out_data, out_valid
    );

    modport slave (
        input  req_data, req_valid, credit_return,
        output req_ready, out_data, out_valid
    );
endinterface

// File: rtl/spine_egress_scheduler_arb.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr
// in ascending modulo-NREQ order.
//   req    : request vector
//   rr_ptr : highest-priority index
//   gnt    : one-hot winner (0 when nothing requested)
//   found  : any request present
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt,
    output logic             found
);
    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spine_egress_scheduler.sv
// Packet-level egress scheduler: shares the router-to-NI path among the four
// spine ingress ports. One spine owns the path for a whole packet (round-robin
// choice), and delivery is throttled by a credit counter mirroring the NI
// receive buffer.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   arb_enable    : gates new grants only; a packet in flight always completes
//   egress        : request/delivery/credit handshake (slave modport)
//   grant         : one-hot current owner, 0 when idle
//   busy          : packet transfer in progress
//   credit_count  : credits currently available
//   credit_err    : sticky, a credit was returned while already full
module spine_egress_scheduler
    import noc_pkg::*;
#(
    parameter int unsigned DWIDTH    = FLIT_W,
    parameter int unsigned NREQ      = NUM_SPINES,
    parameter int unsigned PKT_FLITS = 4,
    parameter int unsigned CREDITS   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    arb_enable,
    spine_egress_scheduler_if.slave egress,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [3:0]              credit_count,
    output logic                    credit_err
);
    localparam int unsigned     PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned     CNT_W      = $clog2(PKT_FLITS);
    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PKT_FLITS - 1);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NREQ - 1);
    localparam logic [3:0]      CREDIT_MAX = 4'(CREDITS);

    sched_state_t     state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] arb_idx;
    logic [CNT_W-1:0] flit_cnt;
    logic [NREQ-1:0]  arb_gnt;
    logic             arb_found;
    logic             accept;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req    (egress.req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .found  (arb_found)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
        end
    end

    // grant is 0 outside XFER, so ready needs no explicit state term.
    assign egress.req_ready = (credit_count != '0) ? grant : '0;
    assign accept           = |(egress.req_valid & egress.req_ready);
    assign busy             = (state == XFER);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state            <= IDLE;
            grant            <= '0;
            grant_idx        <= '0;
            rr_ptr           <= '0;
            flit_cnt         <= '0;
            egress.out_valid <= 1'b0;
            egress.out_data  <= '0;
            credit_count     <= CREDIT_MAX;
            credit_err       <= 1'b0;
        end else begin
            egress.out_valid <= accept;
            if (accept) egress.out_data <= egress.req_data[grant_idx*DWIDTH +: DWIDTH];

            // Accept and return in the same cycle cancel out.
            if (accept && !egress.credit_return) begin
                credit_count <= credit_count - 1'b1;
            end else if (!accept && egress.credit_return) begin
                if (credit_count == CREDIT_MAX) credit_err   <= 1'b1;
                else                            credit_count <= credit_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arb_enable && arb_found) begin
                        grant     <= arb_gnt;
                        grant_idx <= arb_idx;
                        flit_cnt  <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        flit_cnt <= flit_cnt + 1'b1;
                        if (flit_cnt == LAST_FLIT) begin
                            state  <= IDLE;
                            grant  <= '0;
                            rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spine_egress_scheduler.sv
module tb_spine_egress_scheduler;
    localparam int CREDITS = 4;
    localparam int PKT     = 4;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic arb_enable;
    logic [3:0] grant;
    logic busy;
    logic [3:0] credit_count;
    logic credit_err;

    spine_egress_scheduler_if #(.DWIDTH(16), .NREQ(4)) sif ();

    spine_egress_scheduler #(
        .DWIDTH(16), .NREQ(4), .PKT_FLITS(PKT), .CREDITS(CREDITS)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .arb_enable   (arb_enable),
        .egress       (sif),
        .grant        (grant),
        .busy         (busy),
        .credit_count (credit_count),
        .credit_err   (credit_err)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source FIFOs (stimulus side) ----------------
    logic [15:0] fl [4][64];
    int          head [4];
    int          tail [4];
    logic [3:0]  pend;
    logic        cr_ret;
    logic        arb_en;

    task automatic load(input int sp, input logic [15:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            fl[sp][tail[sp]] = base + 16'(j);
            tail[sp]++;
        end
    endtask

    task automatic drive_inputs();
        logic [3:0]  v;
        logic [63:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                v[i]          = 1'b1;
                d[i*16 +: 16] = fl[i][head[i]];
            end
        end
        sif.req_valid     = v;
        sif.req_data      = d;
        sif.credit_return = cr_ret;
        arb_enable        = arb_en;
        pend              = v & sif.req_ready;
    endtask

    task automatic tick();
        @(negedge ACLK);
        #2;
        for (int i = 0; i < 4; i++) if (pend[i]) head[i]++;
        drive_inputs();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        pend = '0;
        drive_inputs();
    endtask

    // ---------------- behavioural model ----------------
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_sent  = 0;
    int         m_cred  = CREDITS;
    logic       m_err   = 1'b0;
    logic       m_ov    = 1'b0;
    logic [15:0] m_od   = '0;

    // Return a credit whenever the model says the NI buffer is not full.
    task automatic refill(input int n);
        repeat (n) begin
            cr_ret = (m_cred < CREDITS);
            tick();
        end
        cr_ret = 1'b0;
        tick();
    endtask

    initial begin
        forever begin
            @(posedge ACLK or negedge ARESETn);
            if (!ARESETn) begin
                m_owner = -1; m_ptr = 0; m_sent = 0;
                m_cred = CREDITS; m_err = 1'b0; m_ov = 1'b0; m_od = '0;
            end else begin
                logic acc;
                logic picked;
                acc = (m_owner >= 0) && (m_cred > 0) && sif.req_valid[m_owner[1:0]];
                m_ov = acc;
                if (acc) m_od = 16'(sif.req_data >> (m_owner * 16));
                if (acc && !sif.credit_return) m_cred--;
                else if (!acc && sif.credit_return) begin
                    if (m_cred == CREDITS) m_err = 1'b1;
                    else m_cred++;
                end
                if (m_owner < 0) begin
                    picked = 1'b0;
                    if (arb_enable) begin
                        for (int k = 0; k < 4; k++) begin
                            int c;
                            c = (m_ptr + k) % 4;
                            if (!picked && sif.req_valid[c[1:0]]) begin
                                m_owner = c;
                                m_sent  = 0;
                                picked  = 1'b1;
                            end
                        end
                    end
                end else if (acc) begin
                    m_sent++;
                    if (m_sent == PKT) begin
                        m_ptr   = (m_owner + 1) % 4;
                        m_owner = -1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + monitor ----------------
    logic [15:0] olog [$];
    int          gseq [$];
    logic [3:0]  prev_grant = '0;

    initial begin
        forever begin
            logic [3:0] eg;
            logic [3:0] er;
            @(negedge ACLK);
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
            er = (m_owner >= 0 && m_cred > 0) ? eg : 4'd0;
            chk("grant",        32'(grant),         32'(eg));
            chk("req_ready",    32'(sif.req_ready), 32'(er));
            chk("busy",         32'(busy),          32'(m_owner >= 0));
            chk("out_valid",    32'(sif.out_valid), 32'(m_ov));
            chk("out_data",     32'(sif.out_data),  32'(m_od));
            chk("credit_count", 32'(credit_count),  32'(m_cred));
            chk("credit_err",   32'(credit_err),    32'(m_err));
            if (sif.out_valid) olog.push_back(sif.out_data);
            if (grant != prev_grant && grant != '0) begin
                for (int i = 0; i < 4; i++) if (grant[i]) gseq.push_back(i);
            end
            prev_grant = grant;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        ARESETn = 1'b1;
        cr_ret  = 1'b0;
        arb_en  = 1'b0;
        clear_sources();
        #1 ARESETn = 1'b0;
        #7;
        chk("rst_grant",     32'(grant),            32'h0);
        chk("rst_out_valid", 32'(sif.out_valid),    32'h0);
        chk("rst_out_data",  32'(sif.out_data),     32'h0);
        chk("rst_req_ready", 32'(sif.req_ready),    32'h0);
        chk("rst_busy",      32'(busy),             32'h0);
        chk("rst_credits",   32'(credit_count),     32'd4);
        chk("rst_cerr",      32'(credit_err),       32'h0);
        #4 ARESETn = 1'b1;

        // Single packet from spine index 1
        arb_en = 1'b1;
        olog.delete();
        load(1, 16'h1001, 4);
        tick();
        tick();
        chk("t1_grant", 32'(grant), 32'b0010);
        repeat (5) tick();
        chk("t1_nflits", 32'(olog.size()), 32'd4);
        for (int j = 0; j < 4; j++) chk("t1_flit", 32'(olog[j]), 32'(16'h1001 + 16'(j)));
        chk("t1_credits", 32'(credit_count), 32'd0);
        chk("t1_idle",    32'(grant),        32'h0);
        refill(6);

        // Credit stall: spine0 drains credits, spine1 is then held
        load(0, 16'h3001, 4);
        load(1, 16'h4001, 4);
        repeat (10) tick();
        chk("t2_grant",   32'(grant),         32'b0010);
        chk("t2_ready",   32'(sif.req_ready), 32'h0);
        chk("t2_credits", 32'(credit_count),  32'd0);
        olog.delete();
        cr_ret = 1'b1;
        tick();
        cr_ret = 1'b0;
        repeat (3) tick();
        chk("t2_one_flit", 32'(olog.size()), 32'd1);
        chk("t2_flit",     32'(olog[0]),     32'h4001);
        refill(15);

        // Simultaneous accept + return at count 2, then overflow return
        load(2, 16'h6001, 4);
        tick();
        tick();
        tick();
        cr_ret = 1'b1;
        tick();
        cr_ret = 1'b0;
        tick();
        chk("t3_credits_hold", 32'(credit_count), 32'd2);
        refill(10);
        chk("t3_full", 32'(credit_count), 32'd4);
        cr_ret = 1'b1;
        tick();
        cr_ret = 1'b0;
        tick();
        tick();
        chk("t3_cerr",     32'(credit_err),   32'h1);
        chk("t3_credits4", 32'(credit_count), 32'd4);

        // arb_enable dropped mid-packet
        load(3, 16'h7001, 4);
        load(0, 16'h8001, 4);
        tick();
        tick();
        chk("t4_grant3", 32'(grant), 32'b1000);
        arb_en = 1'b0;
        refill(8);
        chk("t4_no_grant", 32'(grant),      32'h0);
        chk("t4_not_busy", 32'(busy),       32'h0);
        chk("t4_cerr_sticky", 32'(credit_err), 32'h1);
        arb_en = 1'b1;
        tick();
        tick();
        chk("t4_grant0", 32'(grant), 32'b0001);
        refill(8);

        // Async reset at flit 2 of 4
        load(1, 16'h9001, 4);
        tick();
        tick();
        tick();
        tick();
        #1 ARESETn = 1'b0;
        clear_sources();
        #1;
        chk("t5_out_valid", 32'(sif.out_valid), 32'h0);
        chk("t5_grant",     32'(grant),         32'h0);
        chk("t5_ready",     32'(sif.req_ready), 32'h0);
        chk("t5_credits",   32'(credit_count),  32'd4);
        chk("t5_cerr",      32'(credit_err),    32'h0);
        #3 ARESETn = 1'b1;
        load(0, 16'hA001, 4);
        load(2, 16'hB001, 4);
        tick();
        tick();
        chk("t5_first_grant", 32'(grant), 32'b0001);
        refill(14);

        // Round-robin fairness from a fresh reset
        #1 ARESETn = 1'b0;
        clear_sources();
        #4 ARESETn = 1'b1;
        olog.delete();
        gseq.delete();
        for (int i = 0; i < 4; i++) load(i, 16'((i + 1) << 12) + 16'h1, 8);
        refill(50);
        for (int k = 0; k < 5; k++) chk("t6_order", 32'(gseq[k]), 32'(k % 4));
        chk("t6_nflits", 32'(olog.size()), 32'd32);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk("t6_flit", 32'(olog[4*k + j]),
                    32'(((k % 4) + 1) << 12) + 32'((k / 4) * 4 + j + 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
